// File: rtl/uart_imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_imem_loader_pkg
// Desc    : Shared constants for the UART instruction-memory loader.
// Rev     : 1.0
// ============================================================================
package uart_imem_loader_pkg;

   localparam logic [1:0] UART_IDLE  = 2'd0;
   localparam logic [1:0] UART_START = 2'd1;
   localparam logic [1:0] UART_DATA  = 2'd2;
   localparam logic [1:0] UART_STOP  = 2'd3;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int BYTES_PER_WORD       = 4;
   localparam int LANE_W               = $clog2(BYTES_PER_WORD);

endpackage
`default_nettype wire

// File: rtl/uart_imem_loader_rx_byte.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_byte
// Desc   : 8N1 UART byte receiver with 2-FF input synchronizer.
// Rev    : 1.0
// ============================================================================
module uart_rx_byte
   import uart_imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       enable,
   input  logic       abort,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int            CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] c_HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] c_FULL_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

   logic          r_meta, r_sync, r_prev;
   logic [1:0]    r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          w_start_edge, w_half, w_full;

   assign w_start_edge = r_prev & ~r_sync;
   assign w_half       = (r_cnt == c_HALF_CNT);
   assign w_full       = (r_cnt == c_FULL_CNT);
   assign rx_byte      = r_shift;

   // Line idles high, so the synchronizer resets to 1 to avoid a false start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= rx;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= UART_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state || (r_state == UART_DATA && w_full))
            r_cnt <= '0;
         else if (r_state != UART_IDLE)
            r_cnt <= r_cnt + c_CNT_ONE;
         if (r_state == UART_START) begin
            r_bit <= '0;
         end else if (r_state == UART_DATA && w_full) begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= {r_sync, r_shift[7:1]};
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         UART_IDLE:  if (enable && w_start_edge) w_next = UART_START;
         UART_START: if (w_half) w_next = r_sync ? UART_IDLE : UART_DATA;
         UART_DATA:  if (w_full && r_bit == 3'd7) w_next = UART_STOP;
         UART_STOP:  if (w_full) w_next = UART_IDLE;
         default:    w_next = UART_IDLE;
      endcase
      if (abort) w_next = UART_IDLE;
   end

   always_comb begin
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      if (r_state == UART_STOP && w_full && !abort) begin
         rx_valid = r_sync;
         rx_ferr  = ~r_sync;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module : uart_imem_loader
// Desc   : Loads a little-endian program image from UART into instruction memory.
// Rev    : 1.0
// ============================================================================
module uart_imem_loader
   import uart_imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int ADDR_WIDTH   = 6,
   parameter int DEPTH        = 64,
   parameter int XLEN         = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  load_en,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [XLEN-1:0]       wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  frame_err,
   output logic [ADDR_WIDTH:0]   word_cnt
);

   localparam logic [ADDR_WIDTH:0]   c_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [LANE_W-1:0]     c_LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
   localparam logic [LANE_W-1:0]     c_LANE_ONE  = LANE_W'(1);

   logic [7:0]            w_rx_byte;
   logic                  w_rx_valid, w_rx_ferr;
   logic                  w_load_rise, w_load_fall;
   logic                  r_load_d, r_we, r_done, r_ferr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_word_cnt;
   logic [LANE_W-1:0]     r_lane;
   logic [XLEN-1:0]       r_wdata;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .enable   (load_en & ~r_done),
      .abort    (~load_en | r_done),
      .rx_byte  (w_rx_byte),
      .rx_valid (w_rx_valid),
      .rx_ferr  (w_rx_ferr)
   );

   assign w_load_rise = load_en & ~r_load_d;
   assign w_load_fall = ~load_en & r_load_d;

   // Session control has priority over byte intake; a closing session drops any partial word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load_d   <= 1'b0;
         r_we       <= 1'b0;
         r_done     <= 1'b0;
         r_ferr     <= 1'b0;
         r_addr     <= '0;
         r_word_cnt <= '0;
         r_lane     <= '0;
         r_wdata    <= '0;
      end else begin
         r_load_d <= load_en;
         r_we     <= 1'b0;
         if (w_load_rise) begin
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_lane     <= '0;
         end else if (w_load_fall) begin
            r_done <= 1'b1;
            r_lane <= '0;
         end else if (r_we) begin
            r_addr     <= r_addr + c_ADDR_ONE;
            r_word_cnt <= r_word_cnt + c_CNT_ONE;
            r_lane     <= '0;
            if (r_word_cnt + c_CNT_ONE == c_DEPTH) r_done <= 1'b1;
         end else if (load_en && !r_done) begin
            if (w_rx_ferr) begin
               r_ferr <= 1'b1;
               r_lane <= '0;
            end else if (w_rx_valid) begin
               r_wdata[{r_lane, 3'b000} +: 8] <= w_rx_byte;
               if (r_lane == c_LAST_LANE) r_we   <= 1'b1;
               else                       r_lane <= r_lane + c_LANE_ONE;
            end
         end
      end
   end

   assign we        = r_we;
   assign waddr     = r_addr;
   assign wdata     = r_wdata;
   assign done      = r_done;
   assign frame_err = r_ferr;
   assign word_cnt  = r_word_cnt;
   assign busy      = r_load_d & load_en & ~r_done;

endmodule
`default_nettype wire
